// File: rtl/amo_sequencer_pkg.sv
// Shared types for the A-extension sequencer: operation, sign and size encodings,
// FSM state and the request legality helpers.
package amo_sequencer_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned RSV_LSB_DEF = 2;

    typedef enum logic [3:0] {
        ASEL_X    = 4'd0,
        ASEL_LR   = 4'd1,
        ASEL_SC   = 4'd2,
        ASEL_SWAP = 4'd3,
        ASEL_ADD  = 4'd4,
        ASEL_XOR  = 4'd5,
        ASEL_AND  = 4'd6,
        ASEL_OR   = 4'd7,
        ASEL_MAX  = 4'd8,
        ASEL_MIN  = 4'd9
    } AextSel;

    typedef enum logic {
        OP_UNSIGNED = 1'b0,
        OP_SIGNED   = 1'b1
    } SignSel;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } MemSize;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } AmoState;

    // Encodings above ASEL_MIN are reserved and rejected like ASEL_X.
    function automatic logic sel_supported(input logic [3:0] sel);
        return (sel >= 4'd1) && (sel <= 4'd9);
    endfunction

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = lo[0];
            SIZE_W:  mis = |lo[1:0];
            default: mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/amo_sequencer_alu.sv
// Combinational read-modify-write function for AMO operations: new = f(old, src).
module amo_alu
    import amo_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [3:0]      sel_i,
    input  logic            sign_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    output logic [XLEN-1:0] res_o
);

    logic old_lt_src;

    always_comb begin
        old_lt_src = (sign_i == OP_SIGNED) ? ($signed(old_i) < $signed(src_i))
                                           : (old_i < src_i);
        res_o = src_i;
        case (sel_i)
            ASEL_SWAP: res_o = src_i;
            ASEL_ADD:  res_o = old_i + src_i;
            ASEL_XOR:  res_o = old_i ^ src_i;
            ASEL_AND:  res_o = old_i & src_i;
            ASEL_OR:   res_o = old_i | src_i;
            ASEL_MAX:  res_o = old_lt_src ? src_i : old_i;
            ASEL_MIN:  res_o = old_lt_src ? old_i : src_i;
            default:   res_o = src_i;
        endcase
    end

endmodule

// File: rtl/amo_sequencer.sv
// Sequences LR/SC/AMO requests onto the data-memory port and owns the single
// LR/SC reservation. All outputs except req_ready decode registered state only.
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RSV_LSB = RSV_LSB_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_sel,
    input  logic            req_sign,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_src,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_cmd_valid,
    input  logic            mem_cmd_ready,
    output logic            mem_cmd_wen,
    output logic [XLEN-1:0] mem_cmd_addr,
    output logic [XLEN-1:0] mem_cmd_wdata,
    output logic [1:0]      mem_cmd_size,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    input  logic            rsv_clear,
    output logic            busy,
    output logic            rsv_valid,
    output AmoState         dbg_state
);

    localparam int unsigned TAG_W = XLEN - RSV_LSB;

    AmoState           state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic              sign_q, sign_d;
    logic [1:0]        size_q, size_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;
    logic              rsv_valid_q, rsv_valid_d;
    logic [TAG_W-1:0]  rsv_tag_q, rsv_tag_d;

    logic              req_err;
    logic              rsv_hit;
    logic [XLEN-1:0]   alu_res;

    assign req_err = !sel_supported(req_sel) || (req_size != SIZE_W)
                     || addr_misaligned(req_size, req_addr[2:0]);
    assign rsv_hit = rsv_valid_q && (req_addr[XLEN-1:RSV_LSB] == rsv_tag_q);

    amo_alu #(.XLEN(XLEN)) u_alu (
        .sel_i  (sel_q),
        .sign_i (sign_q),
        .old_i  (data_q),
        .src_i  (src_q),
        .res_o  (alu_res)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        sign_d        = sign_q;
        size_d        = size_q;
        addr_d        = addr_q;
        src_d         = src_q;
        data_d        = data_q;
        err_d         = err_q;
        rsv_valid_d   = rsv_valid_q;
        rsv_tag_d     = rsv_tag_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_wen   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sel_d  = req_sel;
                    sign_d = req_sign;
                    size_d = req_size;
                    addr_d = req_addr;
                    src_d  = req_src;
                    err_d  = req_err;
                    data_d = '0;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_sel == ASEL_LR) begin
                        state_d = RD_REQ;
                    end else if (req_sel == ASEL_SC) begin
                        // A same-cycle rsv_clear beats the SC.
                        rsv_valid_d = 1'b0;
                        if (rsv_hit && !rsv_clear) begin
                            state_d = WR_REQ;
                        end else begin
                            data_d  = {{(XLEN-1){1'b0}}, 1'b1};
                            state_d = RESP;
                        end
                    end else begin
                        if (rsv_hit) rsv_valid_d = 1'b0;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d = mem_rsp_rdata;
                    if (sel_q == ASEL_LR) begin
                        rsv_valid_d = 1'b1;
                        rsv_tag_d   = addr_q[XLEN-1:RSV_LSB];
                        state_d     = RESP;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_wen   = 1'b1;
                if (mem_cmd_ready) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_rsp_valid) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Applied last so a clear always wins over an LR setting the reservation.
        if (rsv_clear) rsv_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sign_q      <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            rsv_valid_q <= 1'b0;
            rsv_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sign_q      <= sign_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            src_q       <= src_d;
            data_q      <= data_d;
            err_q       <= err_d;
            rsv_valid_q <= rsv_valid_d;
            rsv_tag_q   <= rsv_tag_d;
        end
    end

    assign mem_cmd_addr  = mem_cmd_valid ? addr_q : '0;
    assign mem_cmd_size  = mem_cmd_valid ? size_q : 2'b00;
    assign mem_cmd_wdata = mem_cmd_wen ? ((sel_q == ASEL_SC) ? src_q : alu_res) : '0;
    assign resp_rdata    = resp_valid ? data_q : '0;
    assign resp_err      = resp_valid & err_q;
    assign busy          = (state_q != IDLE);
    assign rsv_valid     = rsv_valid_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Randomized and directed scoreboard bench for amo_sequencer with a memory responder
// and a transaction-level reference model of memory and the reservation.
module tb_amo_sequencer;
    import amo_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_sel = '0;
    logic        req_sign = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_src = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b1;
    logic        mem_cmd_wen;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic [1:0]  mem_cmd_size;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        rsv_clear = 1'b0;
    logic        busy;
    logic        rsv_valid;
    AmoState     dbg_state;

    always #5 clk = ~clk;

    amo_sequencer #(.XLEN(32), .RSV_LSB(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_sign(req_sign), .req_size(req_size), .req_addr(req_addr), .req_src(req_src),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wen(mem_cmd_wen),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_size(mem_cmd_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .rsv_clear(rsv_clear), .busy(busy), .rsv_valid(rsv_valid), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];      // {rsv_valid, err, rdata}
    logic [64:0] exp_cmd_q[$];  // {wen, addr, wdata}

    logic [31:0] ref_mem[int unsigned];
    logic [31:0] phys_mem[int unsigned];
    logic        m_rsv = 1'b0;
    logic [29:0] m_rsv_tag = '0;

    int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
    int rsp_delay_min = 0;
    int rsp_delay_max = 0;
    int hs_cnt = 0;
    int hs_done = 0;
    int rsp_wait = -1;
    logic [31:0] rsp_data_n = '0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a >> 2) ? phys_mem[a >> 2] : 32'h0;
    endfunction

    task automatic set_mem(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a >> 2]  = v;
        phys_mem[a >> 2] = v;
    endtask

    function automatic logic [31:0] ref_f(input logic [3:0] sel, input logic sign,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = sign ? longint'($signed(a)) : longint'(a);
        sb = sign ? longint'($signed(b)) : longint'(b);
        case (sel)
            ASEL_ADD: return a + b;
            ASEL_XOR: return a ^ b;
            ASEL_AND: return a & b;
            ASEL_OR:  return a | b;
            ASEL_MAX: return (sa >= sb) ? a : b;
            ASEL_MIN: return (sa <= sb) ? a : b;
            default:  return b;
        endcase
    endfunction

    // Reference: whole-transaction effect on memory, reservation and rd.
    task automatic model_issue(input logic [3:0] sel, input logic sign, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] src, input logic clr);
        logic [31:0] old;
        logic ok;
        if (clr) m_rsv = 1'b0;
        if (sel == 4'd0 || sel > 4'd9 || size != 2'd2 || addr[1:0] != 2'd0) begin
            exp_q.push_back({m_rsv, 1'b1, 32'h0});
            return;
        end
        old = ref_rd(addr);
        if (sel == ASEL_LR) begin
            exp_cmd_q.push_back({1'b0, addr, 32'h0});
            m_rsv = 1'b1;
            m_rsv_tag = addr[31:2];
            exp_q.push_back({1'b1, 1'b0, old});
        end else if (sel == ASEL_SC) begin
            ok = m_rsv && (m_rsv_tag == addr[31:2]);
            m_rsv = 1'b0;
            if (ok) begin
                exp_cmd_q.push_back({1'b1, addr, src});
                ref_mem[addr >> 2] = src;
            end
            exp_q.push_back({1'b0, 1'b0, ok ? 32'd0 : 32'd1});
        end else begin
            exp_cmd_q.push_back({1'b0, addr, 32'h0});
            exp_cmd_q.push_back({1'b1, addr, ref_f(sel, sign, old, src)});
            ref_mem[addr >> 2] = ref_f(sel, sign, old, src);
            if (m_rsv && m_rsv_tag == addr[31:2]) m_rsv = 1'b0;
            exp_q.push_back({m_rsv, 1'b0, old});
        end
    endtask

    // Memory side: command monitor/executor on negedge, response driver after posedge.
    always @(negedge clk) begin : mem_cmd_mon
        logic [64:0] e;
        if (rst_n && mem_cmd_valid && mem_cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
                check("cmd_unexpected", {31'h0, mem_cmd_wen}, 32'hFFFF_FFFF);
            end else begin
                e = exp_cmd_q.pop_front();
                check("cmd_wen", {31'h0, mem_cmd_wen}, {31'h0, e[64]});
                check("cmd_addr", mem_cmd_addr, e[63:32]);
                if (e[64]) check("cmd_wdata", mem_cmd_wdata, e[31:0]);
                check("cmd_size", {30'h0, mem_cmd_size}, 32'd2);
            end
            rsp_data_n = phys_rd(mem_cmd_addr);
            if (mem_cmd_wen) phys_mem[mem_cmd_addr >> 2] = mem_cmd_wdata;
            hs_cnt++;
        end
    end

    always @(posedge clk) begin : mem_rsp_drv
        #1;
        mem_rsp_valid = 1'b0;
        if (!rst_n) begin
            hs_done  = hs_cnt;
            rsp_wait = -1;
        end else if (hs_done != hs_cnt) begin
            if (rsp_wait < 0) rsp_wait = $urandom_range(rsp_delay_min, rsp_delay_max);
            if (rsp_wait == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rsp_data_n;
                hs_done = hs_cnt;
                rsp_wait = -1;
            end else begin
                rsp_wait--;
            end
        end
        case (ready_mode)
            0:       mem_cmd_ready = 1'b1;
            1:       mem_cmd_ready = ($urandom_range(0, 3) != 0);
            default: mem_cmd_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin : resp_mon
        logic [33:0] e;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", resp_rdata, 32'hDEAD_BEEF ^ resp_rdata ^ 32'h1);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
                check("resp_rdata", resp_rdata, e[31:0]);
                check("rsv_valid", {31'h0, rsv_valid}, {31'h0, e[33]});
            end
        end
    end

    // Both handshakes must hold their payload stable while stalled.
    logic        cmd_stall_prev = 1'b0;
    logic [64:0] cmd_prev = '0;
    logic        resp_hold_prev = 1'b0;
    logic [32:0] resp_prev = '0;
    always @(negedge clk) begin : stable_mon
        if (!rst_n) begin
            cmd_stall_prev = 1'b0;
            resp_hold_prev = 1'b0;
        end else begin
            if (cmd_stall_prev)
                check("cmd_hold", {31'h0, mem_cmd_valid && ({mem_cmd_wen, mem_cmd_addr, mem_cmd_wdata} == cmd_prev)}, 32'd1);
            if (resp_hold_prev)
                check("resp_hold", {31'h0, resp_valid && ({resp_err, resp_rdata} == resp_prev)}, 32'd1);
            cmd_stall_prev = mem_cmd_valid && !mem_cmd_ready;
            cmd_prev       = {mem_cmd_wen, mem_cmd_addr, mem_cmd_wdata};
            resp_hold_prev = resp_valid && !resp_ready;
            resp_prev      = {resp_err, resp_rdata};
            if (cmd_stall_prev) stall_cnt++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
        check({tag, "_resp_err"}, {31'h0, resp_err}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_cmd_valid"}, {31'h0, mem_cmd_valid}, 32'd0);
        check({tag, "_cmd_wen"}, {31'h0, mem_cmd_wen}, 32'd0);
        check({tag, "_cmd_addr"}, mem_cmd_addr, 32'd0);
        check({tag, "_cmd_wdata"}, mem_cmd_wdata, 32'd0);
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_rsv_valid"}, {31'h0, rsv_valid}, 32'd0);
    endtask

    // Issue one request, optionally hold resp_ready low, optionally check latency.
    task automatic issue(input logic [3:0] sel, input logic sign, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] src, input logic clr,
                         input int hold, input int exp_lat);
        int n;
        logic [31:0] held;
        @(posedge clk); #1;
        req_valid = 1'b1; req_sel = sel; req_sign = sign; req_size = size;
        req_addr = addr; req_src = src; rsv_clear = clr;
        resp_ready = (hold == 0);
        model_issue(sel, sign, size, addr, src, clr);
        @(negedge clk);
        check("req_ready_at_issue", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; rsv_clear = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 200);
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        else if (exp_lat >= 0) check("latency", n, exp_lat);
        if (hold > 0) begin
            held = resp_rdata;
            repeat (hold) begin
                @(negedge clk);
                check("held_valid", {31'h0, resp_valid}, 32'd1);
                check("held_rdata", resp_rdata, held);
            end
            @(posedge clk); #1;
            resp_ready = 1'b1;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("resp_drain", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin : main
        logic [31:0] saved, last_lr, addr, src;
        logic [3:0]  sel;
        logic [1:0]  size;
        int n, r, s0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_mem(32'h100, 32'h7FFF_FFFF);
        issue(ASEL_ADD, OP_SIGNED, SIZE_W, 32'h100, 32'd1, 1'b0, 0, 5);
        set_mem(32'h104, 32'hFFFF_FFFF);
        issue(ASEL_MAX, OP_SIGNED, SIZE_W, 32'h104, 32'd1, 1'b0, 0, 5);
        set_mem(32'h108, 32'hFFFF_FFFF);
        issue(ASEL_MAX, OP_UNSIGNED, SIZE_W, 32'h108, 32'd1, 1'b0, 0, 5);
        check("max_signed_mem", phys_rd(32'h104), 32'd1);
        check("max_unsigned_mem", phys_rd(32'h108), 32'hFFFF_FFFF);

        set_mem(32'h200, 32'h55);
        issue(ASEL_LR, OP_SIGNED, SIZE_W, 32'h200, 32'd0, 1'b0, 0, 3);
        issue(ASEL_SC, OP_SIGNED, SIZE_W, 32'h204, 32'd9, 1'b0, 0, 1);
        issue(ASEL_LR, OP_SIGNED, SIZE_W, 32'h200, 32'd0, 1'b0, 0, 3);
        issue(ASEL_SC, OP_SIGNED, SIZE_W, 32'h200, 32'd9, 1'b0, 0, 3);
        check("sc_mem", phys_rd(32'h200), 32'd9);

        set_mem(32'h300, 32'hABCD);
        issue(ASEL_LR, OP_SIGNED, SIZE_W, 32'h300, 32'd0, 1'b0, 0, 3);
        issue(ASEL_SC, OP_SIGNED, SIZE_W, 32'h300, 32'd5, 1'b1, 0, 1);
        check("clr_sc_mem", phys_rd(32'h300), 32'hABCD);

        issue(ASEL_SWAP, OP_SIGNED, SIZE_W, 32'h102, 32'h1234, 1'b0, 0, 1);
        issue(ASEL_SWAP, OP_SIGNED, SIZE_H, 32'h100, 32'h1234, 1'b0, 0, 1);
        issue(ASEL_X, OP_SIGNED, SIZE_W, 32'h100, 32'h1234, 1'b0, 0, 1);

        set_mem(32'h10C, 32'h0F0F_0F0F);
        s0 = stall_cnt;
        ready_mode = 2;
        fork
            issue(ASEL_XOR, OP_SIGNED, SIZE_W, 32'h10C, 32'hFFFF_0000, 1'b0, 0, -1);
            begin
                repeat (6) @(posedge clk);
                ready_mode = 0;
            end
        join
        check("stall_cycles", {31'h0, (stall_cnt - s0) >= 4}, 32'd1);

        set_mem(32'h110, 32'h0000_00F0);
        issue(ASEL_OR, OP_SIGNED, SIZE_W, 32'h110, 32'h0000_000F, 1'b0, 3, 5);

        // Reset while waiting for the read data of an AMO.
        set_mem(32'h800, 32'h11);
        saved = ref_rd(32'h800);
        rsp_delay_min = 6; rsp_delay_max = 6;
        @(posedge clk); #1;
        req_valid = 1'b1; req_sel = ASEL_ADD; req_sign = 1'b0; req_size = SIZE_W;
        req_addr = 32'h800; req_src = 32'd1;
        model_issue(ASEL_ADD, 1'b0, SIZE_W, 32'h800, 32'd1, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dbg_state != RD_WAIT && n < 20);
        check("reached_rd_wait", {31'h0, dbg_state == RD_WAIT}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        exp_cmd_q.delete();
        ref_mem[32'h800 >> 2] = saved;
        m_rsv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_delay_min = 0; rsp_delay_max = 0;
        issue(ASEL_SWAP, OP_SIGNED, SIZE_W, 32'h800, 32'h22, 1'b0, 0, 5);

        for (int k = 0; k < 8; k++) set_mem(32'h400 + 32'(4 * k), $urandom);
        ready_mode = 1;
        rsp_delay_max = 2;
        last_lr = 32'h400;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 4)       sel = ASEL_LR;
            else if (r < 8)  sel = ASEL_SC;
            else if (r < 17) sel = 4'($urandom_range(3, 9));
            else             sel = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(10, 15));
            addr = 32'h400 + 32'(4 * $urandom_range(0, 7));
            if (sel == ASEL_SC && $urandom_range(0, 2) != 0) addr = last_lr;
            if (sel == ASEL_LR) last_lr = addr;
            if ($urandom_range(0, 15) == 0) addr = addr + 32'($urandom_range(1, 3));
            size = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            src = $urandom;
            issue(sel, 1'($urandom_range(0, 1)), size, addr, src,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, -1);
        end

        ready_mode = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("cmd_queue_empty", exp_cmd_q.size(), 32'd0);
        check("final_idle", {31'h0, busy}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
